// File: rtl/requant_sat_int4_stage_pkg.sv
// Shared types and saturation helper for the int4 requant stage.
// REQUANT_RELU_EN narrows the output range to [0,7] (fused ReLU).
package dscmp_pkg;

  localparam int Q_W       = 4;
  localparam int ACC_W_DEF = 32;
  localparam int P_W       = 48;

`ifdef REQUANT_RELU_EN
  localparam int QMIN = 0;
`else
  localparam int QMIN = -8;
`endif
  localparam int QMAX = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  function automatic logic signed [Q_W-1:0] sat_q(
    input logic signed [P_W-1:0] v
  );
    logic signed [P_W-1:0] lo;
    logic signed [P_W-1:0] hi;
    lo = P_W'(QMIN);
    hi = P_W'(QMAX);
    if (v < lo) begin
      sat_q = lo[Q_W-1:0];
    end else if (v > hi) begin
      sat_q = hi[Q_W-1:0];
    end else begin
      sat_q = v[Q_W-1:0];
    end
  endfunction

endpackage

// File: rtl/requant_sat_int4_stage_unit.sv
// One registered stage: multiply, round-half-up shift, saturate to int4.
// Carries the element index and valid alongside the result.
module requant_unit
  import dscmp_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int IW    = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [IW-1:0]           in_idx,
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [15:0]      mult,
  input  logic [4:0]              shift,
  output logic                    out_valid,
  output logic [IW-1:0]           out_idx,
  output logic signed [Q_W-1:0]   q
);

  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] rnd;
  logic signed [P_W-1:0] sum;
  logic signed [P_W-1:0] shr;
  logic signed [Q_W-1:0] q_d;

  always_comb begin
    prod = acc * mult;
    rnd  = '0;
    if (shift != 5'd0) begin
      rnd[shift - 5'd1] = 1'b1;
    end
    sum = prod + rnd;
    shr = sum >>> shift;
    q_d = sat_q(shr);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      q         <= '0;
    end else begin
      out_valid <= in_valid;
      out_idx   <= in_idx;
      if (in_valid) begin
        q <= q_d;
      end
    end
  end

endmodule

// File: rtl/requant_sat_int4_stage.sv
// Streams int32 accumulators, requantizes to int4 into a local buffer.
// Build option REQUANT_RELU_EN clamps negative results to 0.
module requant_sat_int4_stage
  import dscmp_pkg::*;
#(
  parameter int BATCHES = 16,
  parameter int H       = 112,
  parameter int W       = 112,
  parameter int CH      = 144,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic signed [15:0]      scale_mult,
  input  logic [4:0]              scale_shift,
  output logic [31:0]             src_addr,
  input  logic signed [ACC_W-1:0] src_data,
  input  logic [31:0]             read_addr,
  output logic signed [Q_W-1:0]   read_data,
  output logic                    busy,
  output logic                    done
);

  localparam int N_ELEM = BATCHES * H * W * CH;
  localparam int AW     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [AW-1:0] LAST = AW'(N_ELEM - 1);

  state_t                state_q;
  logic [AW-1:0]         addr_q;
  logic                  v0_q;
  logic                  v1_q;
  logic [AW-1:0]         idx1_q;
  logic                  busy_q;
  logic                  done_q;
  logic signed [15:0]    mult_q;
  logic [4:0]            shift_q;
  logic signed [Q_W-1:0] rd_q;

  logic                  v2;
  logic [AW-1:0]         idx2;
  logic signed [Q_W-1:0] q2;

  logic signed [Q_W-1:0] mem_q [N_ELEM];

  // v0: addr_q is being issued; v1: src_data belongs to idx1_q
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      idx1_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mult_q  <= '0;
      shift_q <= '0;
    end else begin
      v1_q   <= v0_q;
      idx1_q <= addr_q;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            mult_q  <= scale_mult;
            shift_q <= scale_shift;
            addr_q  <= '0;
            v0_q    <= 1'b1;
          end
        end
        RUN: begin
          if (v0_q) begin
            if (addr_q == LAST) begin
              v0_q <= 1'b0;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
          if (v2 && (idx2 == LAST)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  requant_unit #(
    .ACC_W(ACC_W),
    .IW   (AW)
  ) u_rq (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (v1_q),
    .in_idx   (idx1_q),
    .acc      (src_data),
    .mult     (mult_q),
    .shift    (shift_q),
    .out_valid(v2),
    .out_idx  (idx2),
    .q        (q2)
  );

  always_ff @(posedge clk) begin
    if (resetn && v2) begin
      mem_q[idx2] <= q2;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_q <= '0;
    end else if (read_addr < 32'(N_ELEM)) begin
      rd_q <= mem_q[read_addr[AW-1:0]];
    end else begin
      rd_q <= '0;
    end
  end

  assign src_addr  = 32'(addr_q);
  assign read_data = rd_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_requant_sat_int4_stage.sv
// Directed bench for requant_sat_int4_stage with a 32-element frame.
// Honours REQUANT_RELU_EN for expected negative results.
module tb_requant_sat_int4_stage;

  logic               clk;
  logic               resetn;
  logic               start;
  logic signed [15:0] scale_mult;
  logic [4:0]         scale_shift;
  logic [31:0]        src_addr;
  logic signed [31:0] src_data;
  logic [31:0]        read_addr;
  logic signed [3:0]  read_data;
  logic               busy;
  logic               done;

  logic signed [31:0] src_mem [32];

  int n_pass;
  int n_total;

  requant_sat_int4_stage #(
    .BATCHES(1),
    .H      (4),
    .W      (4),
    .CH     (2),
    .ACC_W  (32)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .scale_mult (scale_mult),
    .scale_shift(scale_shift),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) src_data <= src_mem[src_addr[4:0]];

  function automatic int clampq(input int v);
`ifdef REQUANT_RELU_EN
    int lo = 0;
`else
    int lo = -8;
`endif
    if (v < lo) return lo;
    if (v > 7) return 7;
    return v;
  endfunction

  task automatic do_pass(input logic signed [15:0] m, input logic [4:0] s,
                         input int restart_at, output int cyc,
                         output logic b0);
    scale_mult  = m;
    scale_shift = s;
    start       = 1'b1;
    @(posedge clk); #1;
    b0          = busy;
    start       = 1'b0;
    scale_mult  = 16'sh7fff;
    scale_shift = 5'd31;
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      if (c == restart_at) begin
        start      = 1'b1;
        scale_mult = 16'sd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        cyc = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic signed [3:0] v);
    read_addr = a;
    @(posedge clk); #1;
    v = read_data;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start = 1'b0;
    scale_mult = '0;
    scale_shift = '0;
    read_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({src_addr, read_data, busy, done} !== 38'd0) begin
      $display("FAIL reset: got addr=%0d rd=%0d busy=%0d done=%0d exp 0",
               src_addr, read_data, busy, done);
    end else n_pass++;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    int cyc;
    logic b0;
    logic signed [3:0] v;
    int bad;
    for (int i = 0; i < 32; i++) src_mem[i] = 0;
    do_pass(16'sd1, 5'd0, 0, cyc, b0);
    n_total++;
    if (b0 !== 1'b1) $display("FAIL zero_busy: got %0d exp 1", b0);
    else n_pass++;
    n_total++;
    if (cyc !== 35) $display("FAIL zero_latency: got %0d exp 35", cyc);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd(32'(i), v);
      if (v !== 4'sd0) begin
        bad++;
        $display("FAIL zero_read[%0d]: got %0d exp 0", i, v);
      end
    end
    n_total++;
    if (bad == 0) n_pass++;
  endtask

  task automatic test_ramp;
    int cyc;
    logic b0;
    logic signed [3:0] v;
    for (int i = 0; i < 32; i++) src_mem[i] = i - 16;
    do_pass(16'sd1, 5'd0, 0, cyc, b0);
    n_total++;
    if (cyc !== 35) $display("FAIL ramp_latency: got %0d exp 35", cyc);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      rd(32'(i), v);
      n_total++;
      if (v !== clampq(i - 16))
        $display("FAIL ramp_read[%0d]: got %0d exp %0d", i, v, clampq(i - 16));
      else n_pass++;
    end
  endtask

  task automatic test_round;
    int cyc;
    logic b0;
    logic signed [3:0] v;
    int exp_a [5];
    int exp_b [4];
    // mult=3 shift=2
    src_mem[0] = 5;     exp_a[0] = clampq(4);
    src_mem[1] = -6;    exp_a[1] = clampq(-4);
    src_mem[2] = 1000;  exp_a[2] = clampq(750);
    src_mem[3] = -1000; exp_a[3] = clampq(-750);
    src_mem[4] = 2;     exp_a[4] = clampq(2);
    do_pass(16'sd3, 5'd2, 0, cyc, b0);
    n_total++;
    if (cyc !== 35) $display("FAIL round_a_latency: got %0d exp 35", cyc);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      rd(32'(i), v);
      n_total++;
      if (v !== exp_a[i])
        $display("FAIL round_a[%0d]: got %0d exp %0d", i, v, exp_a[i]);
      else n_pass++;
    end
    // mult=1 shift=2
    src_mem[0] = -6; exp_b[0] = clampq(-1);
    src_mem[1] = 5;  exp_b[1] = 1;
    src_mem[2] = 6;  exp_b[2] = 2;
    src_mem[3] = -2; exp_b[3] = 0;
    do_pass(16'sd1, 5'd2, 0, cyc, b0);
    for (int i = 0; i < 4; i++) begin
      rd(32'(i), v);
      n_total++;
      if (v !== exp_b[i])
        $display("FAIL round_b[%0d]: got %0d exp %0d", i, v, exp_b[i]);
      else n_pass++;
    end
  endtask

  task automatic test_restart_ignored;
    int cyc;
    logic b0;
    logic signed [3:0] v;
    for (int i = 0; i < 32; i++) src_mem[i] = i - 16;
    do_pass(16'sd1, 5'd0, 10, cyc, b0);
    n_total++;
    if (cyc !== 35) $display("FAIL restart_latency: got %0d exp 35", cyc);
    else n_pass++;
    rd(32'd20, v);
    n_total++;
    if (v !== 4'sd4) $display("FAIL restart_scale: got %0d exp 4", v);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({busy, done} !== 2'b01)
      $display("FAIL restart_idle: got busy=%0d done=%0d exp 0/1", busy, done);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic signed [3:0] v;
    for (int i = 0; i < 32; i++) src_mem[i] = 3;
    scale_mult  = 16'sd2;
    scale_shift = 5'd0;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({busy, done, src_addr} !== 34'd0)
      $display("FAIL midreset: got busy=%0d done=%0d addr=%0d exp 0",
               busy, done, src_addr);
    else n_pass++;
    resetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) src_mem[i] = -1;
    begin
      logic b0;
      do_pass(16'sd1, 5'd0, 0, cyc, b0);
    end
    n_total++;
    if (cyc !== 35) $display("FAIL midreset_latency: got %0d exp 35", cyc);
    else n_pass++;
    rd(32'd31, v);
    n_total++;
    if (v !== clampq(-1))
      $display("FAIL midreset_read: got %0d exp %0d", v, clampq(-1));
    else n_pass++;
  endtask

  task automatic test_oob;
    logic signed [3:0] v;
    for (int i = 0; i < 32; i++) src_mem[i] = 7;
    begin
      int cyc;
      logic b0;
      do_pass(16'sd1, 5'd0, 0, cyc, b0);
    end
    rd(32'd5, v);
    n_total++;
    if (v !== 4'sd7) $display("FAIL oob_inrange: got %0d exp 7", v);
    else n_pass++;
    rd(32'd32, v);
    n_total++;
    if (v !== 4'sd0) $display("FAIL oob_32: got %0d exp 0", v);
    else n_pass++;
    rd(32'd6, v);
    rd(32'hFFFF_FFFF, v);
    n_total++;
    if (v !== 4'sd0) $display("FAIL oob_max: got %0d exp 0", v);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 32; i++) src_mem[i] = 0;
    test_reset();
    test_zero();
    test_ramp();
    test_round();
    test_restart_ignored();
    test_reset_mid();
    test_oob();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
